// File: rtl/crossbar_ctl.sv
// Crossbar route controller: round-robin arbitration over route/unsubscribe
// requests, ownership checking against a shadow table, and issue of put strobes.
module crossbar_ctl #(
  parameter int unsigned W   = 3,
  parameter int unsigned N   = 4,
  parameter int unsigned IN  = 4,
  parameter int unsigned OUT = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] req_from_i,
  input  logic [N*W-1:0] req_to_i,
  output logic [N-1:0]   ack_o,
  output logic [N-1:0]   nak_o,
  output logic [W-1:0]   from_o,
  output logic [W-1:0]   to_o,
  output logic           put_o,
  output logic           busy_o
);

  localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OW = (OUT > 1) ? $clog2(OUT) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, GAP} state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   last_q, last_d;
  logic [NW-1:0]   gnt_q, gnt_d;
  logic [W-1:0]    lfrom_q, lfrom_d;
  logic [W-1:0]    lto_q, lto_d;
  logic            accept_q, accept_d;
  logic [OUT-1:0]  valid_q, valid_d;
  logic [NW-1:0]   owner_q [OUT];
  logic [NW-1:0]   owner_d [OUT];
  logic            put_q, put_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [N-1:0]    nak_q, nak_d;
  logic [W-1:0]    from_q, from_d;
  logic [W-1:0]    to_q, to_d;
  logic            busy_q, busy_d;

  logic            rr_found;
  logic [NW-1:0]   rr_idx;
  int unsigned     cand;
  logic [W-1:0]    sel_from, sel_to;
  logic [OW-1:0]   slot;
  logic            in_range, is_unsub, decide;

  // Round-robin search starting just after the last grant.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_q) + k) % N;
      if (!rr_found && req_i[NW'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = NW'(cand);
      end
    end
  end

  always_comb begin
    sel_from = '0;
    sel_to   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (NW'(k) == rr_idx) begin
        sel_from = req_from_i[k*W +: W];
        sel_to   = req_to_i[k*W +: W];
      end
    end
  end

  // Ownership decision on the latched request; slot is only meaningful when in range.
  always_comb begin
    slot     = OW'(lto_q);
    in_range = (32'(lto_q) < OUT);
    is_unsub = lfrom_q[W-1] || (32'(lfrom_q) >= IN);
    if (is_unsub) begin
      decide = in_range && valid_q[slot] && (owner_q[slot] == gnt_q);
    end else begin
      decide = in_range && (!valid_q[slot] || (owner_q[slot] == gnt_q));
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    lfrom_d  = lfrom_q;
    lto_d    = lto_q;
    accept_d = accept_q;
    valid_d  = valid_q;
    owner_d  = owner_q;
    put_d    = 1'b0;
    ack_d    = '0;
    nak_d    = '0;
    from_d   = from_q;
    to_d     = to_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d = CHECK;
          gnt_d   = rr_idx;
          last_d  = rr_idx;
          lfrom_d = sel_from;
          lto_d   = sel_to;
        end
      end
      CHECK: begin
        accept_d = decide;
        state_d  = ISSUE;
      end
      ISSUE: begin
        state_d = GAP;
        if (accept_q) begin
          put_d        = 1'b1;
          ack_d[gnt_q] = 1'b1;
          from_d       = lfrom_q;
          to_d         = lto_q;
          valid_d[slot] = !is_unsub;
          if (!is_unsub) begin
            owner_d[slot] = gnt_q;
          end
        end else begin
          nak_d[gnt_q] = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= NW'(N - 1);
      gnt_q    <= '0;
      lfrom_q  <= '0;
      lto_q    <= '0;
      accept_q <= 1'b0;
      valid_q  <= '0;
      owner_q  <= '{default: '0};
      put_q    <= 1'b0;
      ack_q    <= '0;
      nak_q    <= '0;
      from_q   <= '0;
      to_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      lfrom_q  <= lfrom_d;
      lto_q    <= lto_d;
      accept_q <= accept_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      put_q    <= put_d;
      ack_q    <= ack_d;
      nak_q    <= nak_d;
      from_q   <= from_d;
      to_q     <= to_d;
      busy_q   <= busy_d;
    end
  end

  assign ack_o  = ack_q;
  assign nak_o  = nak_q;
  assign put_o  = put_q;
  assign from_o = from_q;
  assign to_o   = to_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_crossbar_ctl.sv
// Scoreboard bench for crossbar_ctl: a spec-level ownership model predicts each
// response; a monitor pops and compares whenever an ack/nak/put appears.
module tb_crossbar_ctl;

  localparam int W   = 3;
  localparam int N   = 4;
  localparam int IN  = 4;
  localparam int OUT = 4;

  typedef struct {
    logic [N-1:0] ack;
    logic [N-1:0] nak;
    logic         put;
    logic [W-1:0] from;
    logic [W-1:0] to;
  } exp_t;

  logic           clk, rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_from, req_to;
  logic [N-1:0]   ack, nak;
  logic [W-1:0]   from_v, to_v;
  logic           put, busy;

  crossbar_ctl #(.W(W), .N(N), .IN(IN), .OUT(OUT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_from_i(req_from), .req_to_i(req_to),
    .ack_o(ack), .nak_o(nak), .from_o(from_v), .to_o(to_v), .put_o(put), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [W-1:0] exp_from = '0, exp_to = '0;

  // Reference state: which requester owns each output, and the last grant.
  bit   m_valid [OUT];
  int   m_owner [OUT];
  int   m_last;
  logic [W-1:0] bf [N];
  logic [W-1:0] bt [N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < OUT; i++) begin
      m_valid[i] = 1'b0;
      m_owner[i] = 0;
    end
    m_last = N - 1;
  endfunction

  function automatic int pick(input logic [N-1:0] p);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (p[c]) return c;
    end
    return 0;
  endfunction

  function automatic exp_t model(input int g, input logic [W-1:0] f, input logic [W-1:0] t);
    exp_t e;
    bit   unsub, ok;
    int   fi, ti;
    fi = int'(f);
    ti = int'(t);
    e.ack = '0; e.nak = '0; e.put = 1'b0; e.from = f; e.to = t;
    unsub = f[W-1] || (fi >= IN);
    if (ti >= OUT)  ok = 1'b0;
    else if (unsub) ok = m_valid[ti] && (m_owner[ti] == g);
    else            ok = !m_valid[ti] || (m_owner[ti] == g);
    if (ok) begin
      e.ack[g] = 1'b1;
      e.put    = 1'b1;
      if (unsub) m_valid[ti] = 1'b0;
      else begin
        m_valid[ti] = 1'b1;
        m_owner[ti] = g;
      end
    end else begin
      e.nak[g] = 1'b1;
    end
    m_last = g;
    return e;
  endfunction

  // Monitor: compare each presented response against the next expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (put || (|ack) || (|nak)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: ack=%b nak=%b put=%b but none expected", ack, nak, put);
        end else begin
          mon_e = q.pop_front();
          chk("ack", int'(ack), int'(mon_e.ack));
          chk("nak", int'(nak), int'(mon_e.nak));
          chk("put", int'(put), int'(mon_e.put));
          if (mon_e.put) begin
            exp_from = mon_e.from;
            exp_to   = mon_e.to;
          end
        end
      end
      chk("from_o", int'(from_v), int'(exp_from));
      chk("to_o", int'(to_v), int'(exp_to));
    end
  end

  task automatic wait_resp(input int g, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack[g] || nak[g]) && n < 12);
    if (!(ack[g] || nak[g])) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: requester %0d got no ack/nak within %0d cycles", g, n);
    end
  endtask

  task automatic run_batch(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int n, g;
    bit first;
    exp_t e;
    pend  = mask;
    first = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        req_from[i*W +: W] = bf[i];
        req_to[i*W +: W]   = bt[i];
      end
    end
    req = req | mask;
    while (pend != '0) begin
      g = pick(pend);
      e = model(g, bf[g], bt[g]);
      q.push_back(e);
      wait_resp(g, n);
      chk("latency", n, first ? 3 : 4);
      chk("busy_at_resp", int'(busy), 1);
      req[g]  = 1'b0;
      pend[g] = 1'b0;
      first   = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      chk("busy_idle", int'(busy), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_from = '0;
    req_to = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_put", int'(put), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_nak", int'(nak), 0);
    chk("rst_from", int'(from_v), 0);
    chk("rst_to", int'(to_v), 0);
    rst = 1'b0;

    // First route straight out of reset, then a conflicting route and an unsubscribe.
    bf[0] = 3'd0; bt[0] = 3'd0; run_batch(4'b0001);
    bf[1] = 3'd2; bt[1] = 3'd0; run_batch(4'b0010);
    bf[0] = 3'd7; bt[0] = 3'd0; run_batch(4'b0001);
    bf[2] = 3'd1; bt[2] = 3'd4; run_batch(4'b0100);
    bf[1] = 3'd3; bt[1] = 3'd2; run_batch(4'b0010);
    bf[1] = 3'd3; bt[1] = 3'd1; run_batch(4'b0010);
    bf[1] = 3'd6; bt[1] = 3'd1; run_batch(4'b0010);
    bf[3] = 3'd0; bt[3] = 3'd2; run_batch(4'b1000);

    // Reset while the FSM sits in CHECK.
    @(negedge clk);
    req_from[0 +: W] = 3'd1;
    req_to[0 +: W]   = 3'd3;
    req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    exp_from = '0;
    exp_to   = '0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_put", int'(put), 0);
    chk("midrst_from", int'(from_v), 0);
    chk("midrst_to", int'(to_v), 0);
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", int'({put, ack, nak}), 0);
    end

    for (int i = 0; i < N; i++) begin
      bf[i] = W'($urandom_range(0, 3));
      bt[i] = W'((i + 2) % OUT);
    end
    run_batch(4'b1111);
    bf[0] = 3'd1; bt[0] = 3'd2;
    bf[3] = 3'd2; bt[3] = 3'd1;
    run_batch(4'b1001);

    repeat (30) begin
      for (int i = 0; i < N; i++) begin
        bf[i] = W'($urandom_range(0, 7));
        bt[i] = W'($urandom_range(0, 5));
      end
      run_batch(N'($urandom_range(1, (1 << N) - 1)));
    end

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
